spi_flash_rd_seq: RTL and testbench

SPI_FLASH_RD_SEQ -- requirements
Module: spi_flash_rd_seq

---
 rtl/spi_flash_rd_seq_pkg.sv | 54 +++++
 rtl/spi_flash_rd_seq_busmux.sv | 49 ++++
 rtl/spi_flash_rd_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_rd_seq_pkg.sv
// Shared definitions for the SPI flash read sequencer: peripheral register
// offsets, status bit index, flash command codes and the sequencer state enum.
// Build option: SPI_SEQ_FASTREAD_EN selects FAST_READ (0x0B + one dummy byte)
// instead of READ (0x03).
package spi_flash_rd_seq_pkg;

    localparam logic [11:0] REG_TX   = 12'h008;
    localparam logic [11:0] REG_RX   = 12'h00C;
    localparam logic [11:0] REG_STAT = 12'h010;
    localparam logic [11:0] REG_CS   = 12'h014;

    localparam int STAT_RXNE_BIT = 3;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

`ifdef SPI_SEQ_FASTREAD_EN
    localparam logic [7:0] CMD_SEL   = CMD_FAST_READ;
    localparam int         HDR_BYTES = 5;
`else
    localparam logic [7:0] CMD_SEL   = CMD_READ;
    localparam int         HDR_BYTES = 4;
`endif

    localparam logic [2:0] HDR_LAST_IDX = 3'(HDR_BYTES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_LO,
        ST_HDR_WR,
        ST_HDR_POLL,
        ST_HDR_RD,
        ST_DAT_WR,
        ST_DAT_POLL,
        ST_DAT_RD,
        ST_DAT_OUT,
        ST_CS_HI,
        ST_DONE
    } seq_state_t;

    // Header byte sequence: command, address MSB..LSB, then dummy byte(s).
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_SEL;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_rd_seq_busmux.sv
// Request mux between the CPU and the read engine in front of the SPI
// peripheral. While the engine owns the bus the CPU sees no ready and its
// request never reaches the master port.
module spi_seq_busmux
    import spi_flash_rd_seq_pkg::*;
(
    input  logic        eng_sel,
    input  logic [11:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    input  logic        cpu_mem_valid,
    output logic [31:0] cpu_mem_rdata,
    output logic        cpu_mem_ready,
    input  logic [11:0] eng_addr,
    input  logic [31:0] eng_wdata,
    input  logic [3:0]  eng_wstrb,
    input  logic        eng_valid,
    output logic [31:0] eng_rdata,
    output logic        eng_ready,
    output logic [11:0] m_mem_addr,
    output logic [31:0] m_mem_wdata,
    output logic [3:0]  m_mem_wstrb,
    output logic        m_mem_valid,
    input  logic [31:0] m_mem_rdata,
    input  logic        m_mem_ready
);

    // Select the bus owner; the CPU is stalled while the engine owns it.
    always_comb begin
        m_mem_addr    = cpu_mem_addr;
        m_mem_wdata   = cpu_mem_wdata;
        m_mem_wstrb   = cpu_mem_wstrb;
        m_mem_valid   = cpu_mem_valid;
        cpu_mem_ready = m_mem_ready;
        eng_ready     = 1'b0;
        if (eng_sel) begin
            m_mem_addr    = eng_addr;
            m_mem_wdata   = eng_wdata;
            m_mem_wstrb   = eng_wstrb;
            m_mem_valid   = eng_valid;
            cpu_mem_ready = 1'b0;
            eng_ready     = m_mem_ready;
        end
    end

    assign cpu_mem_rdata = m_mem_rdata;
    assign eng_rdata     = m_mem_rdata;

endmodule

// File: rtl/spi_flash_rd_seq.sv
// SPI flash read sequencer. Takes over the SPI peripheral bus between CPU
// accesses, issues a READ (or FAST_READ with SPI_SEQ_FASTREAD_EN) header and
// streams job_len bytes out one at a time, keeping a single byte in flight.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | CPU owns the bus; accept pending job once CPU bus is quiet
// CS_LO     | write 0 to CS_n register (select flash)
// HDR_WR    | write current header byte to TX
// HDR_POLL  | read status until RX not empty
// HDR_RD    | read and drop the echoed header byte
// DAT_WR    | write 0x00 to TX to clock in one data byte
// DAT_POLL  | read status until RX not empty
// DAT_RD    | read RX, latch data byte
// DAT_OUT   | present byte on rd_data/rd_valid until rd_ready
// CS_HI     | write 1 to CS_n register (deselect flash)
// DONE      | one-cycle job_done, then back to IDLE
module spi_flash_rd_seq
    import spi_flash_rd_seq_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter bit HDR_DRAIN = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [11:0]      cpu_mem_addr,
    input  logic [31:0]      cpu_mem_wdata,
    input  logic [3:0]       cpu_mem_wstrb,
    input  logic             cpu_mem_valid,
    output logic [31:0]      cpu_mem_rdata,
    output logic             cpu_mem_ready,
    output logic [11:0]      m_mem_addr,
    output logic [31:0]      m_mem_wdata,
    output logic [3:0]       m_mem_wstrb,
    output logic             m_mem_valid,
    input  logic [31:0]      m_mem_rdata,
    input  logic             m_mem_ready,
    input  logic             job_start,
    input  logic [23:0]      job_addr,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_busy,
    output logic             job_done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    seq_state_t       state_q, state_d;
    logic             pending_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] remain_q;
    logic [2:0]       hdr_idx_q;
    logic [7:0]       rd_data_q;

    logic [11:0]      eng_addr;
    logic [31:0]      eng_wdata;
    logic [3:0]       eng_wstrb;
    logic             eng_valid;
    logic [31:0]      eng_rdata;
    logic             eng_ready;

    logic             accept;
    logic             hdr_last;
    logic             rx_ne;
    logic             unused_rdata;

    assign accept       = (state_q == ST_IDLE) && pending_q && !cpu_mem_valid;
    assign hdr_last     = (hdr_idx_q == HDR_LAST_IDX);
    assign rx_ne        = eng_rdata[STAT_RXNE_BIT];
    assign unused_rdata = ^eng_rdata[31:8];

    assign job_busy = (state_q != ST_IDLE);
    assign job_done = (state_q == ST_DONE);
    assign rd_valid = (state_q == ST_DAT_OUT);
    assign rd_data  = rd_data_q;

    spi_seq_busmux u_busmux (
        .eng_sel       (job_busy),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_rdata (cpu_mem_rdata),
        .cpu_mem_ready (cpu_mem_ready),
        .eng_addr      (eng_addr),
        .eng_wdata     (eng_wdata),
        .eng_wstrb     (eng_wstrb),
        .eng_valid     (eng_valid),
        .eng_rdata     (eng_rdata),
        .eng_ready     (eng_ready),
        .m_mem_addr    (m_mem_addr),
        .m_mem_wdata   (m_mem_wdata),
        .m_mem_wstrb   (m_mem_wstrb),
        .m_mem_valid   (m_mem_valid),
        .m_mem_rdata   (m_mem_rdata),
        .m_mem_ready   (m_mem_ready)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and engine bus request; the request depends only on state
    // and held registers, so it stays stable until the cycle ready is seen.
    always_comb begin
        state_d   = state_q;
        eng_valid = 1'b0;
        eng_addr  = REG_STAT;
        eng_wdata = 32'h0;
        eng_wstrb = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (job_len == '0) ? ST_DONE : ST_CS_LO;
                end
            end
            ST_CS_LO: begin
                eng_valid = 1'b1;
                eng_addr  = REG_CS;
                eng_wdata = 32'h0;
                eng_wstrb = 4'h1;
                if (eng_ready) state_d = ST_HDR_WR;
            end
            ST_HDR_WR: begin
                eng_valid = 1'b1;
                eng_addr  = REG_TX;
                eng_wdata = {24'h0, hdr_byte(hdr_idx_q, addr_q)};
                eng_wstrb = 4'h1;
                if (eng_ready) begin
                    if (HDR_DRAIN)     state_d = ST_HDR_POLL;
                    else if (hdr_last) state_d = ST_DAT_WR;
                    else               state_d = ST_HDR_WR;
                end
            end
            ST_HDR_POLL: begin
                eng_valid = 1'b1;
                eng_addr  = REG_STAT;
                if (eng_ready && rx_ne) state_d = ST_HDR_RD;
            end
            ST_HDR_RD: begin
                eng_valid = 1'b1;
                eng_addr  = REG_RX;
                if (eng_ready) state_d = hdr_last ? ST_DAT_WR : ST_HDR_WR;
            end
            ST_DAT_WR: begin
                eng_valid = 1'b1;
                eng_addr  = REG_TX;
                eng_wdata = 32'h0;
                eng_wstrb = 4'h1;
                if (eng_ready) state_d = ST_DAT_POLL;
            end
            ST_DAT_POLL: begin
                eng_valid = 1'b1;
                eng_addr  = REG_STAT;
                if (eng_ready && rx_ne) state_d = ST_DAT_RD;
            end
            ST_DAT_RD: begin
                eng_valid = 1'b1;
                eng_addr  = REG_RX;
                if (eng_ready) state_d = ST_DAT_OUT;
            end
            ST_DAT_OUT: begin
                if (rd_ready) begin
                    state_d = (remain_q == LEN_W'(1)) ? ST_CS_HI : ST_DAT_WR;
                end
            end
            ST_CS_HI: begin
                eng_valid = 1'b1;
                eng_addr  = REG_CS;
                eng_wdata = 32'h1;
                eng_wstrb = 4'h1;
                if (eng_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job request latch: one pending job at most, starts ignored while busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= 1'b0;
        end else if (accept) begin
            pending_q <= 1'b0;
        end else if (job_start && (state_q == ST_IDLE) && !pending_q) begin
            pending_q <= 1'b1;
        end
    end

    // Job parameters, header index and remaining byte down-counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= 24'h0;
            remain_q  <= '0;
            hdr_idx_q <= 3'd0;
        end else begin
            if (accept) begin
                addr_q    <= job_addr;
                remain_q  <= job_len;
                hdr_idx_q <= 3'd0;
            end
            if (eng_ready && (((state_q == ST_HDR_WR) && !HDR_DRAIN) ||
                              (state_q == ST_HDR_RD))) begin
                hdr_idx_q <= hdr_idx_q + 3'd1;
            end
            if ((state_q == ST_DAT_OUT) && rd_ready) begin
                remain_q <= remain_q - LEN_W'(1);
            end
        end
    end

    // Data byte capture from the RX register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= 8'h00;
        end else if ((state_q == ST_DAT_RD) && eng_ready) begin
            rd_data_q <= eng_rdata[7:0];
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Directed bench for spi_flash_rd_seq with a behavioural SPI peripheral:
// TX writes echo a byte (0xA0 + TX index since CS went low) into a
// one-entry RX slot a few cycles later. Honours SPI_SEQ_FASTREAD_EN.
module tb_spi_flash_rd_seq;

`ifdef SPI_SEQ_FASTREAD_EN
    localparam int         HL  = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HL  = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] cpu_mem_addr = '0;
    logic [31:0] cpu_mem_wdata = '0;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic        cpu_mem_valid = 1'b0;
    logic [31:0] cpu_mem_rdata;
    logic        cpu_mem_ready;
    logic [11:0] m_mem_addr;
    logic [31:0] m_mem_wdata;
    logic [3:0]  m_mem_wstrb;
    logic        m_mem_valid;
    logic [31:0] m_mem_rdata = '0;
    logic        m_mem_ready = 1'b0;
    logic        job_start = 1'b0;
    logic [23:0] job_addr = '0;
    logic [15:0] job_len = '0;
    logic        job_busy;
    logic        job_done;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #4 clk = ~clk;

    spi_flash_rd_seq #(.LEN_W(16), .HDR_DRAIN(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_ready(cpu_mem_ready),
        .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata),
        .m_mem_wstrb(m_mem_wstrb), .m_mem_valid(m_mem_valid),
        .m_mem_rdata(m_mem_rdata), .m_mem_ready(m_mem_ready),
        .job_start(job_start), .job_addr(job_addr), .job_len(job_len),
        .job_busy(job_busy), .job_done(job_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    // ---------------- peripheral model ----------------
    int         lat = 0;
    int         wcnt = 0;
    int         tx_idx = 0;
    int         pend_t = 0;
    logic       pend_v = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    logic       rx_v = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       fifo_viol = 1'b0;
    int         m_txn = 0;
    int         done_cnt = 0;
    logic [7:0] tx_log[$];
    logic       cs_log[$];
    logic [7:0] st_log[$];
    logic [7:0] exp_tx[$];
    logic       exp_cs[$];
    logic [7:0] exp_st[$];

    always @(posedge clk) begin
        if (pend_v) begin
            if (pend_t == 0) begin
                rx_v    <= 1'b1;
                rx_byte <= pend_byte;
                pend_v  <= 1'b0;
            end else begin
                pend_t <= pend_t - 1;
            end
        end
        if (m_mem_valid && m_mem_ready) begin
            m_mem_ready <= 1'b0;
            wcnt        <= 0;
            m_txn       <= m_txn + 1;
            case (m_mem_addr)
                12'h008: begin
                    tx_log.push_back(m_mem_wdata[7:0]);
                    if (pend_v || rx_v) fifo_viol <= 1'b1;
                    pend_v    <= 1'b1;
                    pend_t    <= 2;
                    pend_byte <= 8'hA0 + tx_idx[7:0];
                    tx_idx    <= tx_idx + 1;
                end
                12'h014: begin
                    cs_log.push_back(m_mem_wdata[0]);
                    if (!m_mem_wdata[0]) tx_idx <= 0;
                end
                12'h00C: begin
                    if (!rx_v) fifo_viol <= 1'b1;
                    rx_v <= 1'b0;
                end
                default: ;
            endcase
        end else if (m_mem_valid) begin
            if (wcnt >= lat) begin
                m_mem_ready <= 1'b1;
                case (m_mem_addr)
                    12'h010: m_mem_rdata <= {28'h0, rx_v, 3'b000};
                    12'h00C: m_mem_rdata <= {24'h0, rx_byte};
                    12'h020: m_mem_rdata <= 32'hCAFE_F00D;
                    default: m_mem_rdata <= 32'h0;
                endcase
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            m_mem_ready <= 1'b0;
            wcnt        <= 0;
        end
    end

    // Handshake stability and strobe rules on the master port.
    logic        hs_pend = 1'b0;
    logic        hs_viol = 1'b0;
    logic [11:0] hs_a = '0;
    logic [31:0] hs_d = '0;
    logic [3:0]  hs_s = '0;
    always @(posedge clk) begin
        if (hs_pend && (!m_mem_valid || m_mem_addr != hs_a ||
                        m_mem_wdata != hs_d || m_mem_wstrb != hs_s)) hs_viol <= 1'b1;
        if (m_mem_valid && (m_mem_addr == 12'h008 || m_mem_addr == 12'h014) && m_mem_wstrb != 4'h1)
            hs_viol <= 1'b1;
        if (m_mem_valid && (m_mem_addr == 12'h00C || m_mem_addr == 12'h010) && m_mem_wstrb != 4'h0)
            hs_viol <= 1'b1;
        hs_pend <= rstn && m_mem_valid && !m_mem_ready;
        hs_a    <= m_mem_addr;
        hs_d    <= m_mem_wdata;
        hs_s    <= m_mem_wstrb;
    end

    // Stream and done monitors.
    always @(posedge clk) begin
        if (rd_valid && rd_ready) st_log.push_back(rd_data);
        if (job_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        cs_log.delete();
        st_log.delete();
    endtask

    task automatic build_exp(input logic [23:0] a, input int len);
        exp_tx.delete();
        exp_cs.delete();
        exp_st.delete();
        exp_tx.push_back(CMD);
        exp_tx.push_back(a[23:16]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        if (HL == 5) exp_tx.push_back(8'h00);
        for (int k = 0; k < len; k++) begin
            exp_tx.push_back(8'h00);
            exp_st.push_back(8'(8'hA0 + HL + k));
        end
        exp_cs.push_back(1'b0);
        exp_cs.push_back(1'b1);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_tx_n"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++)
            if (i < tx_log.size()) chk($sformatf("%s_tx%0d", tag, i), {24'h0, tx_log[i]}, {24'h0, exp_tx[i]});
        chk({tag, "_cs_n"}, cs_log.size(), exp_cs.size());
        for (int i = 0; i < exp_cs.size(); i++)
            if (i < cs_log.size()) chk($sformatf("%s_cs%0d", tag, i), {31'h0, cs_log[i]}, {31'h0, exp_cs[i]});
        chk({tag, "_st_n"}, st_log.size(), exp_st.size());
        for (int i = 0; i < exp_st.size(); i++)
            if (i < st_log.size()) chk($sformatf("%s_st%0d", tag, i), {24'h0, st_log[i]}, {24'h0, exp_st[i]});
    endtask

    task automatic start_job(input logic [23:0] a, input logic [15:0] len);
        @(negedge clk);
        job_addr  = a;
        job_len   = len;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (job_done === 1'b1) break;
        end
        chk({tag, "_done"}, {31'h0, job_done}, 32'h1);
        @(negedge clk);
    endtask

    // CPU access; tracks mirroring when idle and stall/isolation when busy.
    task automatic cpu_xfer(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rdat, output bit ok, output bit mirror_bad,
                            output bit stall_bad, output bit saw_busy);
        ok = 0; mirror_bad = 0; stall_bad = 0; saw_busy = 0; rdat = '0;
        cpu_mem_addr  = a;
        cpu_mem_wdata = d;
        cpu_mem_wstrb = s;
        cpu_mem_valid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            #1;
            if (job_busy) begin
                saw_busy = 1;
                if (cpu_mem_ready !== 1'b0) stall_bad = 1;
                if (m_mem_valid && m_mem_addr == a) stall_bad = 1;
            end else begin
                if (m_mem_valid !== 1'b1 || m_mem_addr !== a || m_mem_wdata !== d ||
                    m_mem_wstrb !== s || cpu_mem_ready !== m_mem_ready ||
                    cpu_mem_rdata !== m_mem_rdata) mirror_bad = 1;
                if (cpu_mem_ready === 1'b1) begin
                    ok   = 1;
                    rdat = cpu_mem_rdata;
                    break;
                end
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        cpu_mem_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rdat;
    bit          ok, mb, sb, busy_seen, stable, early;
    logic [7:0]  d0;
    int          t0, n0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'h0, job_busy}, 32'h0);
        chk("rst_done",   {31'h0, job_done}, 32'h0);
        chk("rst_rvalid", {31'h0, rd_valid}, 32'h0);
        chk("rst_rdata",  {24'h0, rd_data},  32'h0);
        chk("rst_mvalid", {31'h0, m_mem_valid}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Idle CPU write CS=0 passes through unchanged.
        lat = 2;
        clear_logs();
        cpu_xfer(12'h014, 32'h0, 4'h1, rdat, ok, mb, sb, busy_seen);
        chk("cpu_wr_ok",     {31'h0, ok}, 32'h1);
        chk("cpu_wr_mirror", {31'h0, mb}, 32'h0);
        chk("cpu_wr_cs_n",   cs_log.size(), 1);
        if (cs_log.size() > 0) chk("cpu_wr_cs_v", {31'h0, cs_log[0]}, 32'h0);

        // Basic job; a second start while busy is ignored.
        lat = 0;
        clear_logs();
        t0 = done_cnt;
        start_job(24'h012345, 16'd3);
        repeat (3) @(negedge clk);
        chk("j1_busy", {31'h0, job_busy}, 32'h1);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        wait_done("j1", 2000);
        repeat (6) @(negedge clk);
        chk("j1_no_rerun", {31'h0, job_busy}, 32'h0);
        chk("j1_done_cnt", done_cnt - t0, 1);
        build_exp(24'h012345, 3);
        check_logs("j1");

        // Consumer back-pressure.
        clear_logs();
        rd_ready = 1'b0;
        start_job(24'h000100, 16'd2);
        for (int n = 0; n < 1000; n++) begin
            if (rd_valid === 1'b1) break;
            @(negedge clk);
        end
        chk("bp_valid", {31'h0, rd_valid}, 32'h1);
        d0 = rd_data;
        n0 = tx_log.size();
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (rd_valid !== 1'b1 || rd_data !== d0) stable = 0;
        end
        chk("bp_stable", {31'h0, stable}, 32'h1);
        chk("bp_byte0",  {24'h0, d0}, {24'h0, 8'(8'hA0 + HL)});
        chk("bp_tx_hold", tx_log.size(), n0);
        chk("bp_tx_cnt",  n0, HL + 1);
        rd_ready = 1'b1;
        wait_done("bp", 2000);
        build_exp(24'h000100, 2);
        check_logs("bp");

        // Job requested during an in-flight CPU read.
        lat = 6;
        clear_logs();
        job_addr      = 24'hAABBCC;
        job_len       = 16'd1;
        cpu_mem_addr  = 12'h020;
        cpu_mem_wdata = 32'h0;
        cpu_mem_wstrb = 4'h0;
        cpu_mem_valid = 1'b1;
        @(negedge clk);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        early = 0;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            if (job_busy !== 1'b0) early = 1;
            if (cpu_mem_ready === 1'b1) begin
                ok = 1;
                rdat = cpu_mem_rdata;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        cpu_mem_valid = 1'b0;
        chk("mf_cpu_ok",    {31'h0, ok}, 32'h1);
        chk("mf_cpu_rdata", rdat, 32'hCAFE_F00D);
        chk("mf_no_cut",    {31'h0, early}, 32'h0);
        wait_done("mf", 4000);
        build_exp(24'hAABBCC, 1);
        check_logs("mf");

        // CPU access while busy stalls until after job_done.
        lat = 1;
        clear_logs();
        t0 = done_cnt;
        start_job(24'h00FF00, 16'd1);
        repeat (2) @(negedge clk);
        cpu_xfer(12'h020, 32'h0, 4'h0, rdat, ok, mb, sb, busy_seen);
        chk("st_ok",       {31'h0, ok}, 32'h1);
        chk("st_seen",     {31'h0, busy_seen}, 32'h1);
        chk("st_stall",    {31'h0, sb}, 32'h0);
        chk("st_after",    done_cnt - t0, 1);
        chk("st_rdata",    rdat, 32'hCAFE_F00D);

        // Zero-length job: no bus traffic, done right after acceptance.
        lat = 0;
        clear_logs();
        n0 = m_txn;
        job_len   = 16'd0;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        chk("z_acc_done", {31'h0, job_done}, 32'h0);
        @(negedge clk);
        chk("z_done",     {31'h0, job_done}, 32'h1);
        chk("z_busy",     {31'h0, job_busy}, 32'h1);
        @(negedge clk);
        chk("z_done_off", {31'h0, job_done}, 32'h0);
        chk("z_idle",     {31'h0, job_busy}, 32'h0);
        chk("z_txn",      m_txn - n0, 0);
        chk("z_cs",       cs_log.size(), 0);

        chk("fifo_occ",  {31'h0, fifo_viol}, 32'h0);
        chk("handshake", {31'h0, hs_viol},   32'h0);

        // Reset mid-job abandons it with no further bus cycles.
        start_job(24'h123456, 16'd3);
        repeat (15) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mr_busy",   {31'h0, job_busy}, 32'h0);
        chk("mr_mvalid", {31'h0, m_mem_valid}, 32'h0);
        chk("mr_rvalid", {31'h0, rd_valid}, 32'h0);
        @(negedge clk);
        n0 = m_txn;
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("mr_txn",  m_txn - n0, 0);
        chk("mr_idle", {31'h0, job_busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
